// File: rtl/patseq_pkg.sv
// Shared types and constants for the pattern sequencer: FSM state enum,
// default character width/message, and the parity helper.
package patseq_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_LEN    = 11;
  localparam int DEFAULT_CHAR_W = 7;

  // "CSC137 LAB6" with character 0 in the least-significant slot.
  localparam logic [DEFAULT_LEN*DEFAULT_CHAR_W-1:0] DEFAULT_MSG = {
    7'h36, 7'h42, 7'h41, 7'h4C, 7'h20, 7'h37,
    7'h33, 7'h31, 7'h43, 7'h53, 7'h43
  };

  function automatic logic even_parity(input logic [63:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/patseq_ring.sv
// One-hot ring of LEN positions: load-first, single-step rotate in either
// direction, return-home, and a flag marking the last position of the run.
module patseq_ring #(
  parameter int LEN = 11
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           load,
  input  logic           load_rev,
  input  logic           step,
  input  logic           dir_rev,
  input  logic           home,
  output logic [LEN-1:0] pos,
  output logic           last
);

  logic [LEN-1:0] rot;

  // Shift-and-wrap keeps the ring one-hot; LEN=1 degenerates to a hold.
  always_comb begin
    if (dir_rev) rot = (pos >> 1) | (pos << (LEN-1));
    else         rot = (pos << 1) | (pos >> (LEN-1));
  end

  assign last = dir_rev ? pos[0] : pos[LEN-1];

  always_ff @(posedge CLK) begin
    if (!RST_N)     pos <= LEN'(1);
    else if (home)  pos <= LEN'(1);
    else if (load)  pos <= load_rev ? (LEN'(1) << (LEN-1)) : LEN'(1);
    else if (step)  pos <= rot;
  end

endmodule

// File: rtl/pattern_sequencer.sv
// Character-pattern sequencer: steps a one-hot ring across a LEN-character
// message, one character per valid/ready handshake. Define PATSEQ_PARITY_EN
// to append an even-parity MSB to out_char.
module pattern_sequencer
  import patseq_pkg::*;
#(
  parameter int                     LEN    = DEFAULT_LEN,
  parameter int                     CHAR_W = DEFAULT_CHAR_W,
  parameter logic [LEN*CHAR_W-1:0]  MSG    = DEFAULT_MSG
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_mode,
  input  logic              reverse,
  input  logic              out_ready,
  output logic              out_valid,
`ifdef PATSEQ_PARITY_EN
  output logic [CHAR_W:0]   out_char,
`else
  output logic [CHAR_W-1:0] out_char,
`endif
  output logic [LEN-1:0]    pos,
  output logic              busy,
  output logic              done
);

  localparam logic [0:0] S_IDLE = 1'(ST_IDLE);
  localparam logic [0:0] S_RUN  = 1'(ST_RUN);

  logic [0:0]        state;
  logic              loop_q;
  logic              rev_q;
  logic              done_q;
  logic              run;
  logic              fire;
  logic              load;
  logic              finish;
  logic              home;
  logic              last;
  logic [CHAR_W-1:0] ch;

  assign run    = (state == S_RUN);
  assign fire   = run & out_ready;
  assign load   = ~run & start & ~stop;
  // stop beats a last-character handshake, so no done pulse in that case.
  assign finish = fire & last & ~loop_q & ~stop;
  assign home   = run & (stop | finish);

  patseq_ring #(.LEN(LEN)) u_ring (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (load),
    .load_rev (reverse),
    .step     (fire),
    .dir_rev  (rev_q),
    .home     (home),
    .pos      (pos),
    .last     (last)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      loop_q <= 1'b0;
      rev_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (load) begin
        state  <= S_RUN;
        loop_q <= loop_mode;
        rev_q  <= reverse;
      end else if (home) begin
        state  <= S_IDLE;
      end
    end
  end

  // AND-OR reduction of the one-hot position over the message slots.
  always_comb begin
    ch = '0;
    for (int i = 0; i < LEN; i++) begin
      ch = ch | (MSG[i*CHAR_W +: CHAR_W] & {CHAR_W{pos[i]}});
    end
    if (!run) ch = '0;
  end

`ifdef PATSEQ_PARITY_EN
  assign out_char = {even_parity(64'(ch)), ch};
`else
  assign out_char = ch;
`endif

  assign out_valid = run;
  assign busy      = run;
  assign done      = done_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: index-level reference model
// compared every cycle, plus literal expectations and a LEN=1 instance.
module tb_pattern_sequencer;

  localparam int LEN = 11;
  localparam int CW  = 7;
`ifdef PATSEQ_PARITY_EN
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] C_EXP = 8'hC3;
`else
  localparam int OW = CW;
  localparam logic [OW-1:0] C_EXP = 7'h43;
`endif
  localparam logic [OW-1:0] S_EXP  = OW'(7'h53);
  localparam logic [OW-1:0] SIX_EXP = OW'(7'h36);
  localparam logic [OW-1:0] Z_EXP  = OW'(7'h5A);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, start, stop, loop_mode, reverse, out_ready;
  logic           out_valid, busy, done;
  logic [OW-1:0]  out_char;
  logic [LEN-1:0] pos;

  logic           s1_start, s1_stop, s1_ready;
  logic           u1_valid, u1_busy, u1_done;
  logic [OW-1:0]  u1_char;
  logic [0:0]     u1_pos;

  pattern_sequencer dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .start     (start),
    .stop      (stop),
    .loop_mode (loop_mode),
    .reverse   (reverse),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_char  (out_char),
    .pos       (pos),
    .busy      (busy),
    .done      (done)
  );

  pattern_sequencer #(.LEN(1), .CHAR_W(7), .MSG(7'h5A)) dut1 (
    .CLK       (clk),
    .RST_N     (rst_n),
    .start     (s1_start),
    .stop      (s1_stop),
    .loop_mode (1'b1),
    .reverse   (1'b0),
    .out_ready (s1_ready),
    .out_valid (u1_valid),
    .out_char  (u1_char),
    .pos       (u1_pos),
    .busy      (u1_busy),
    .done      (u1_done)
  );

  logic [6:0] msg [LEN] = '{7'h43, 7'h53, 7'h43, 7'h31, 7'h33, 7'h37,
                            7'h20, 7'h4C, 7'h41, 7'h42, 7'h36};

  int n_checks = 0;
  int n_pass   = 0;

  bit m_run, m_loop, m_rev, m_done;
  int m_idx;

  function automatic logic [OW-1:0] enc(input logic [6:0] c);
`ifdef PATSEQ_PARITY_EN
    return {^c, c};
`else
    return c;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge();
    bit last;
    if (!rst_n) begin
      m_run = 0; m_idx = 0; m_loop = 0; m_rev = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (!m_run) begin
      if (start && !stop) begin
        m_run = 1; m_loop = loop_mode; m_rev = reverse;
        m_idx = reverse ? LEN-1 : 0;
      end
    end else if (stop) begin
      m_run = 0; m_idx = 0;
    end else if (out_ready) begin
      last = m_rev ? (m_idx == 0) : (m_idx == LEN-1);
      if (last && !m_loop) begin
        m_run = 0; m_idx = 0; m_done = 1;
      end else if (m_rev) m_idx = (m_idx + LEN - 1) % LEN;
      else                m_idx = (m_idx + 1) % LEN;
    end
  endtask

  // One clock: advance the model at the edge, then compare just after it.
  task automatic step();
    logic [LEN-1:0] exp_pos;
    logic [OW-1:0]  exp_char;
    @(posedge clk);
    model_edge();
    #1;
    exp_pos  = LEN'(1) << m_idx;
    exp_char = m_run ? enc(msg[m_idx]) : '0;
    chk("pos",       64'(pos),       64'(exp_pos));
    chk("out_valid", 64'(out_valid), 64'(m_run));
    chk("busy",      64'(busy),      64'(m_run));
    chk("done",      64'(done),      64'(m_done));
    chk("out_char",  64'(out_char),  64'(exp_char));
  endtask

  initial begin
    rst_n = 0; start = 0; stop = 0; loop_mode = 0; reverse = 0; out_ready = 0;
    s1_start = 0; s1_stop = 0; s1_ready = 0;
    step(); step();
    chk("reset_pos", 64'(pos), 64'h1);
    chk("reset_u1_pos", 64'(u1_pos), 64'h1);
    rst_n = 1;
    step();
    chk("idle_char_zero", 64'(out_char), 64'h0);

    // LEN=1 loop instance
    s1_start = 1; step(); s1_start = 0;
    chk("len1_busy", 64'(u1_busy), 64'h1);
    chk("len1_char_first", 64'(u1_char), 64'(Z_EXP));
    s1_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("len1_char", 64'(u1_char), 64'(Z_EXP));
      chk("len1_pos", 64'(u1_pos), 64'h1);
      chk("len1_valid", 64'(u1_valid), 64'h1);
    end
    s1_start = 1; step();
    chk("len1_start_ignored", 64'(u1_busy), 64'h1);
    chk("len1_no_done", 64'(u1_done), 64'h0);
    s1_start = 0; s1_stop = 1; step(); s1_stop = 0;
    chk("len1_stop_busy", 64'(u1_busy), 64'h0);
    chk("len1_stop_char", 64'(u1_char), 64'h0);

    // Forward single-shot, ready held high
    start = 1; loop_mode = 0; reverse = 0; out_ready = 1;
    step(); start = 0;
    chk("fwd_first_char", 64'(out_char), 64'(C_EXP));
    step();
    chk("fwd_second_char", 64'(out_char), 64'(S_EXP));
    for (int i = 2; i < LEN; i++) step();
    step();
    chk("fwd_done_pulse", 64'(done), 64'h1);
    chk("fwd_done_busy", 64'(busy), 64'h0);

    // Start during the done cycle is accepted
    start = 1; reverse = 1; out_ready = 0;
    step(); start = 0;
    chk("start_in_done_cycle", 64'(busy), 64'h1);
    chk("rev_first_char", 64'(out_char), 64'(SIX_EXP));
    stop = 1; step(); stop = 0;

    // Reverse loop with ready toggling, then stop
    start = 1; reverse = 1; loop_mode = 1; out_ready = 0;
    step(); start = 0;
    for (int i = 0; i < 30; i++) begin
      out_ready = (i % 2 == 0);
      step();
    end
    stop = 1; step(); stop = 0;
    chk("rev_stop_busy", 64'(busy), 64'h0);
    chk("rev_stop_done", 64'(done), 64'h0);
    step();
    chk("rev_stop_done_after", 64'(done), 64'h0);

    // Stop coincident with last-character handshake
    start = 1; reverse = 0; loop_mode = 0; out_ready = 1;
    step(); start = 0;
    for (int i = 0; i < LEN-1; i++) step();
    chk("at_last_pos", 64'(pos), 64'h400);
    stop = 1; step(); stop = 0;
    chk("stop_last_busy", 64'(busy), 64'h0);
    chk("stop_last_done", 64'(done), 64'h0);
    chk("stop_last_pos", 64'(pos), 64'h1);
    step();
    chk("stop_last_done_after", 64'(done), 64'h0);

    // start together with stop in IDLE
    start = 1; stop = 1; step();
    chk("start_stop_idle", 64'(busy), 64'h0);
    start = 0; stop = 0; step();

    // Hold while not ready, then reset mid-run at bit 5
    start = 1; out_ready = 0; step(); start = 0;
    for (int i = 0; i < 4; i++) step();
    chk("hold_char", 64'(out_char), 64'(C_EXP));
    out_ready = 1; step();
    chk("after_hold_char", 64'(out_char), 64'(S_EXP));
    for (int i = 0; i < 4; i++) step();
    chk("mid_pos5", 64'(pos), 64'h20);
    rst_n = 0; step();
    chk("rst_mid_pos", 64'(pos), 64'h1);
    chk("rst_mid_valid", 64'(out_valid), 64'h0);
    chk("rst_mid_busy", 64'(busy), 64'h0);
    chk("rst_mid_done", 64'(done), 64'h0);
    rst_n = 1; step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
# pattern_sequencer

Parametrised character-pattern sequencer: a one-hot ring of LEN positions steps through a LEN-character message held in a parameter vector. It emits one character per accepted valid/ready handshake, in forward or reverse order, either single-shot or looping. It is the successor to the fixed 11-position ring-counter-plus-encoder name generator, and feeds any character consumer (display driver, UART TX) in the lab designs.

## Interface
- LEN, 11: number of message characters / ring positions, ≥1
- CHAR_W, 7: bits per character
- MSG, ASCII "CSC137 LAB6": LEN*CHAR_W bits; character i at MSG[i*CHAR_W +: CHAR_W], so char 0 = 'C' (0x43) and char 10 = '6' (0x36)
- CLK  in  1  clock, all state updates on rising edge only
- RST_N  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
- start  in  1  begin a sequence; honoured only in IDLE
- stop  in  1  abort the sequence; honoured in RUN
- loop_mode  in  1  1 = wrap forever, 0 = single-shot; sampled at accepted start
- reverse  in  1  1 = run LEN-1 down to 0; sampled at accepted start
- out_ready  in  1  consumer ready
- out_valid  out  1  character available
- out_char  out  CHAR_W (CHAR_W+1 with parity)  current character, all-zero when out_valid=0
- pos  out  LEN  one-hot ring position
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at single-shot completion

## Operation
- States: IDLE, RUN.
- Reset (RST_N=0 at an edge): state IDLE, pos = one-hot bit 0, out_valid=0, out_char=0, busy=0, done=0, latched mode bits=0. Reset overrides every other input, including mid-sequence.
- IDLE with start=1 and stop=0: latch loop_mode/reverse, load pos with bit 0 (forward) or bit LEN-1 (reverse), go to RUN. start=1 together with stop=1 in IDLE: stay in IDLE.
- RUN: out_valid=1 and out_char = MSG character at the pos index, formed as an AND-OR reduction of pos over MSG. A handshake (out_valid & out_ready at an edge) rotates pos by one: up in forward, down in reverse.
- Last position is bit LEN-1 forward, bit 0 reverse. A handshake there:
  - loop_mode=1: wrap to the first position and stay in RUN.
  - loop_mode=0: go to IDLE, pos = bit 0, done=1 for the following cycle.
- stop=1 in RUN: IDLE at that edge, pos = bit 0, no done pulse. A coincident handshake counts as consumed, but stop wins even on the last character, so done stays low.
- start in RUN: ignored. out_ready=0: pos and out_char hold indefinitely.
- LEN=1: the single character is both first and last. In loop mode it repeats every handshake.
- pos is always exactly one-hot; no other encoding is reachable.

## Timing
- Start accepted at edge k: busy=1 and out_valid=1 with the first character from cycle k+1.
- Throughput: one character per cycle while out_ready=1. The next character is visible the cycle after each handshake.
- Single-shot, ready held high: start at edge k, last handshake at edge k+LEN, done=1 and busy=0 during cycle k+LEN+1.
- A start asserted during the done cycle is accepted (state is IDLE).
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.

## Configuration
- PATSEQ_PARITY_EN defined: out_char is CHAR_W+1 bits, with MSB = even parity (XOR) of the character bits. 'C' 0x43 appears as 0xC3. Parity is 0 when out_valid=0.
- Undefined: out_char is CHAR_W bits, no parity logic.

## Structure
- Package patseq_pkg: state enum (ST_IDLE, ST_RUN), default CHAR_W, default MSG constant, parity helper function.
- Sub-module patseq_ring: LEN-bit one-hot rotator with load-first, step, direction, and last-position flag. The top holds the FSM, character mux and handshake.

## Test plan
- Reset mid-RUN (pos at bit 5) -> next cycle pos=bit 0, out_valid=0, busy=0, done=0.
- Forward single-shot, ready held 1 -> chars 0x43,0x53,0x43,0x31,0x33,0x37,0x20,0x4C,0x41,0x42,0x36 on consecutive cycles, then done pulse exactly once, busy low.
- Reverse loop, ready toggled 1/0 -> sequence 0x36,0x42,…,0x43,0x36,… with chars held while ready=0; stop -> IDLE next cycle, no done.
- Stop coincident with last-character handshake in single-shot -> IDLE, done stays 0; start with stop in IDLE -> remains IDLE.
- LEN=1, MSG=0x5A, loop mode -> 0x5A on every handshake, pos constant one-hot bit 0; start during RUN ignored.
- PATSEQ_PARITY_EN build -> first char 0xC3, 'S' 0x53 -> 0x53; out_char=0 when idle.
